alu_sequencer: RTL and testbench

Command-level controller for the 8-bit accumulator ALU datapath. It accepts one operation at a time over a valid/ready handshake and drives the datapath's one-hot input and output selectors and operands. It captures the result one cycle after issue, keeps a shadow accumulator so successive commands can chain, and returns each result with an overflow error flag. It sits between the command source (test harness or host FSM) and the ALU datapath, and owns the off/ready/run/run_error status.

---
 rtl/alu_pkg.sv | 57 +++++
 rtl/alu_sequencer_if.sv | 29 ++
 rtl/alu_op_decode.sv | 28 ++
 rtl/alu_sequencer.sv | 114 +++++++++++
 tb/tb_alu_sequencer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator ALU sequencer.
// Contents: default operand width, status and internal state codes,
// operation codes, and one-hot datapath selector constants.
package alu_pkg;

  localparam int WIDTH = 8;

  // Externally visible status codes
  localparam logic [1:0] S_off       = 2'b00;
  localparam logic [1:0] S_ready     = 2'b01;
  localparam logic [1:0] S_run       = 2'b10;
  localparam logic [1:0] S_run_error = 2'b11;

  // Internal sequencer states
  localparam logic [2:0] ST_OFF     = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_ISSUE   = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_ERROR   = 3'd5;

  // Operation codes
  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_NOT   = 3'd2;
  localparam logic [2:0] OP_XOR   = 3'd3;
  localparam logic [2:0] OP_ADD   = 3'd4;
  localparam logic [2:0] OP_SUB   = 3'd5;
  localparam logic [2:0] OP_MULT  = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  // Datapath input selector {persist, load, reset}
  localparam logic [2:0] SEL_PERSIST = 3'b100;
  localparam logic [2:0] SEL_LOAD    = 3'b010;
  localparam logic [2:0] SEL_RESET   = 3'b001;

  // Datapath output selector, bit6..bit0
  localparam logic [6:0] OUT_AND  = 7'b1000000;
  localparam logic [6:0] OUT_OR   = 7'b0100000;
  localparam logic [6:0] OUT_NOT  = 7'b0010000;
  localparam logic [6:0] OUT_XOR  = 7'b0001000;
  localparam logic [6:0] OUT_ADD  = 7'b0000100;
  localparam logic [6:0] OUT_SUB  = 7'b0000010;
  localparam logic [6:0] OUT_MULT = 7'b0000001;
  localparam logic [6:0] OUT_NONE = 7'b0000000;

  // Collapse internal state onto the 2-bit status code
  function automatic logic [1:0] statusOf(input logic [2:0] s);
    case (s)
      ST_OFF:   return S_off;
      ST_IDLE:  return S_ready;
      ST_ERROR: return S_run_error;
      default:  return S_run;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command/response handshake bundle between a command source and the
// sequencer.
//   master: drives cmd_valid/cmd_op/cmd_load/cmd_acc/cmd_operand, rsp_ready
//   slave : drives cmd_ready, rsp_valid/rsp_data/rsp_error
interface alu_sequencer_if #(parameter int WIDTH = alu_pkg::WIDTH);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic             cmd_load;
  logic [WIDTH-1:0] cmd_acc;
  logic [WIDTH-1:0] cmd_operand;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_error;

  modport master (
    output cmd_valid, cmd_op, cmd_load, cmd_acc, cmd_operand, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_error
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_load, cmd_acc, cmd_operand, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_error
  );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational decode of an operation code.
//   op      in  3  operation code
//   outSel  out 7  one-hot datapath output selector (0 for CLEAR)
//   isClear out 1  operation is CLEAR
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [2:0] op,
  output logic [6:0] outSel,
  output logic       isClear
);

  always_comb begin
    outSel  = OUT_NONE;
    isClear = 1'b0;
    case (op)
      OP_AND:  outSel = OUT_AND;
      OP_OR:   outSel = OUT_OR;
      OP_NOT:  outSel = OUT_NOT;
      OP_XOR:  outSel = OUT_XOR;
      OP_ADD:  outSel = OUT_ADD;
      OP_SUB:  outSel = OUT_SUB;
      OP_MULT: outSel = OUT_MULT;
      default: isClear = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Command-level controller for the accumulator ALU datapath.
//   clk, rst          clock, synchronous active-high reset
//   on                enable, sampled in OFF and IDLE
//   bus (slave)       command/response handshake
//   alu_in_selector   one-hot {persist, load, reset} to datapath
//   alu_num1/num2     operands to datapath
//   alu_out_selector  one-hot operation select to datapath
//   alu_result        datapath result, valid the cycle after issue
//   alu_overflow      datapath multiply overflow
//   state             status: off / ready / run / run_error
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  alu_sequencer_if.slave   bus,
  output logic [2:0]       alu_in_selector,
  output logic [WIDTH-1:0] alu_num1,
  output logic [WIDTH-1:0] alu_num2,
  output logic [6:0]       alu_out_selector,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  output logic [1:0]       state
);

  logic [2:0]       stateQ;
  logic [2:0]       opQ;
  logic             loadQ;
  logic [WIDTH-1:0] accInQ;
  logic [WIDTH-1:0] operandQ;
  logic [WIDTH-1:0] accQ;
  logic [WIDTH-1:0] rspDataQ;
  logic             rspErrorQ;
  logic [6:0]       outSelQ;

  logic [6:0]       decOutSel;
  logic             decClear;
  logic [WIDTH-1:0] capData;
  logic             capError;

  alu_op_decode opDecode (
    .op      (opQ),
    .outSel  (decOutSel),
    .isClear (decClear)
  );

  assign capData  = decClear ? '0 : alu_result;
  assign capError = (opQ == OP_MULT) & alu_overflow;

  assign bus.cmd_ready = (stateQ == ST_IDLE);
  assign bus.rsp_valid = (stateQ == ST_DONE);
  assign bus.rsp_data  = rspDataQ;
  assign bus.rsp_error = rspErrorQ;
  assign state         = statusOf(stateQ);

  // Persist is never used: the datapath recirculates on it every clock,
  // so chaining goes through accQ and a fresh load instead.
  always_comb begin
    alu_in_selector  = SEL_RESET;
    alu_num1         = '0;
    alu_num2         = '0;
    alu_out_selector = outSelQ;
    if (stateQ == ST_ISSUE) begin
      alu_out_selector = decOutSel;
      if (!decClear) begin
        alu_in_selector = SEL_LOAD;
        alu_num1        = loadQ ? accInQ : accQ;
        alu_num2        = operandQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= ST_OFF;
      accQ      <= '0;
      rspDataQ  <= '0;
      rspErrorQ <= 1'b0;
      outSelQ   <= OUT_NONE;
    end else begin
      case (stateQ)
        ST_OFF: if (on) stateQ <= ST_IDLE;
        ST_IDLE: begin
          if (!on) begin
            stateQ <= ST_OFF;
          end else if (bus.cmd_valid) begin
            opQ      <= bus.cmd_op;
            loadQ    <= bus.cmd_load;
            accInQ   <= bus.cmd_acc;
            operandQ <= bus.cmd_operand;
            stateQ   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          outSelQ <= decOutSel;
          stateQ  <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          rspDataQ  <= capData;
          rspErrorQ <= capError;
          accQ      <= capError ? '0 : capData;
          stateQ    <= ST_DONE;
        end
        ST_DONE: if (bus.rsp_ready) stateQ <= rspErrorQ ? ST_ERROR : ST_IDLE;
        ST_ERROR: stateQ <= ST_IDLE;
        default:  stateQ <= ST_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         on;
  logic [2:0]   inSel;
  logic [W-1:0] num1;
  logic [W-1:0] num2;
  logic [6:0]   outSel;
  logic [W-1:0] aluResult;
  logic         aluOverflow;
  logic [1:0]   status;

  always #5 clk = ~clk;

  alu_sequencer_if #(.WIDTH(W)) bus ();

  alu_sequencer #(.WIDTH(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .on               (on),
    .bus              (bus),
    .alu_in_selector  (inSel),
    .alu_num1         (num1),
    .alu_num2         (num2),
    .alu_out_selector (outSel),
    .alu_result       (aluResult),
    .alu_overflow     (aluOverflow),
    .state            (status)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic         err;
  } rsp_t;

  rsp_t         expQ[$];
  int           assertCount = 0;
  int           failCount = 0;
  logic [W-1:0] shadowAcc = '0;
  int           latency;

  // Registered datapath behaviour driven by one-hot selectors
  function automatic logic [W-1:0] dpCompute(input logic [6:0] s, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (s)
      7'b1000000: return a & b;
      7'b0100000: return a | b;
      7'b0010000: return ~a;
      7'b0001000: return a ^ b;
      7'b0000100: return a + b;
      7'b0000010: return a - b;
      7'b0000001: return p[W-1:0];
      default:    return '0;
    endcase
  endfunction

  initial begin
    aluResult   = '0;
    aluOverflow = 1'b0;
  end

  always @(posedge clk) begin
    case (inSel)
      3'b001: begin aluResult <= '0; aluOverflow <= 1'b0; end
      3'b010: begin
        aluResult   <= dpCompute(outSel, num1, num2);
        aluOverflow <= (outSel == 7'b0000001) && ((16'(num1) * 16'(num2)) > 16'd255);
      end
      3'b100: begin
        aluResult   <= dpCompute(outSel, aluResult, num2);
        aluOverflow <= (outSel == 7'b0000001) && ((16'(aluResult) * 16'(num2)) > 16'd255);
      end
      default: ;
    endcase
  end

  // Reference result from the operation code
  function automatic logic [W-1:0] refAlu(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    prod = (2*W)'(a) * (2*W)'(b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~a;
      3'd3: return a ^ b;
      3'd4: return W'((9'(a) + 9'(b)) % 9'd256);
      3'd5: return W'((9'(a) + 9'd256 - 9'(b)) % 9'd256);
      3'd6: return prod[W-1:0];
      default: return '0;
    endcase
  endfunction

  function automatic logic [6:0] refSel(input logic [2:0] op);
    logic [6:0] top;
    top = 7'b1000000;
    return (op == 3'd7) ? 7'b0 : (top >> op);
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one command from a negedge; returns at the negedge inside ISSUE
  task automatic sendCmd(input logic [2:0] op, input logic load, input logic [W-1:0] acc,
                         input logic [W-1:0] operand);
    logic [W-1:0] accIn;
    logic [W-1:0] res;
    logic         err;
    int           waited;
    accIn = load ? acc : shadowAcc;
    res   = refAlu(op, accIn, operand);
    err   = (op == 3'd6) && ((16'(accIn) * 16'(operand)) > 16'd255);
    if (err) res = refAlu(op, accIn, operand);
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_load    = load;
    bus.cmd_acc     = acc;
    bus.cmd_operand = operand;
    waited = 0;
    while (!bus.cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.cmd_ready) checkVal("cmd_ready_timeout", 32'd0, 32'd1);
    expQ.push_back(rsp_t'{data: res, err: err});
    shadowAcc = err ? '0 : res;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    latency = 1;
    checkVal("issue_state", status, S_run);
    checkVal("issue_insel", inSel, (op == 3'd7) ? 3'b001 : 3'b010);
    checkVal("issue_num1", num1, (op == 3'd7) ? 8'h00 : accIn);
    checkVal("issue_num2", num2, (op == 3'd7) ? 8'h00 : operand);
    checkVal("issue_outsel", outSel, refSel(op));
  endtask

  // Wait for the response, optionally stall it, then compare and consume
  task automatic collect(input int hold);
    rsp_t         e;
    logic [W-1:0] d0;
    logic         e0;
    while (!bus.rsp_valid && latency < 20) begin
      @(negedge clk);
      latency++;
    end
    e = (expQ.size() > 0) ? expQ.pop_front() : '0;
    if (!bus.rsp_valid) begin
      checkVal("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    checkVal("rsp_latency", latency, 3);
    d0 = bus.rsp_data;
    e0 = bus.rsp_error;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkVal("hold_stable", {bus.rsp_valid, bus.cmd_ready, bus.rsp_error, bus.rsp_data},
               {1'b1, 1'b0, e0, d0});
    end
    checkVal("rsp_data", bus.rsp_data, e.data);
    checkVal("rsp_error", bus.rsp_error, e.err);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    if (e.err) begin
      checkVal("state_error", status, S_run_error);
      checkVal("error_insel", inSel, SEL_RESET);
      @(negedge clk);
    end
    checkVal("state_ready", status, S_ready);
  endtask

  initial begin
    logic sawValid;
    rst             = 1'b1;
    on              = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = '0;
    bus.cmd_load    = 1'b0;
    bus.cmd_acc     = '0;
    bus.cmd_operand = '0;
    bus.rsp_ready   = 1'b0;
    repeat (2) @(negedge clk);

    checkVal("rst_state", status, S_off);
    checkVal("rst_cmd_ready", bus.cmd_ready, 0);
    checkVal("rst_rsp", {bus.rsp_valid, bus.rsp_error, bus.rsp_data}, 0);
    checkVal("rst_insel", inSel, SEL_RESET);
    checkVal("rst_nums", {num1, num2}, 0);
    checkVal("rst_outsel", outSel, 0);

    rst = 1'b0;
    on  = 1'b1;
    @(negedge clk);
    checkVal("on_state", status, S_ready);
    checkVal("on_cmd_ready", bus.cmd_ready, 1);

    // Load then chain with wrap
    sendCmd(OP_ADD, 1'b1, 8'h05, 8'h03); collect(0);
    sendCmd(OP_ADD, 1'b0, 8'h00, 8'hFE); collect(0);
    // Multiply overflow, then chain from the cleared accumulator
    sendCmd(OP_MULT, 1'b1, 8'h20, 8'h10); collect(0);
    sendCmd(OP_ADD, 1'b0, 8'h00, 8'h01); collect(0);
    // Stalled response
    sendCmd(OP_XOR, 1'b1, 8'hA5, 8'h0F); collect(5);
    // Remaining operations
    sendCmd(OP_SUB, 1'b1, 8'h03, 8'h05); collect(0);
    sendCmd(OP_NOT, 1'b1, 8'h3C, 8'hFF); collect(0);
    sendCmd(OP_AND, 1'b0, 8'h00, 8'h0F); collect(0);
    sendCmd(OP_OR, 1'b0, 8'h00, 8'h50); collect(1);
    sendCmd(OP_MULT, 1'b1, 8'h0F, 8'h11); collect(0);
    sendCmd(OP_CLEAR, 1'b1, 8'h77, 8'h66); collect(0);
    sendCmd(OP_ADD, 1'b0, 8'h00, 8'h07); collect(0);

    // Drop enable mid-command
    sendCmd(OP_OR, 1'b1, 8'h81, 8'h18);
    on = 1'b0;
    collect(0);
    @(negedge clk);
    checkVal("off_after_idle", status, S_off);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    sawValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sawValid = sawValid | bus.cmd_ready | bus.rsp_valid | (status != S_off);
    end
    checkVal("off_ignores_cmd", sawValid, 0);
    bus.cmd_valid = 1'b0;
    on = 1'b1;
    @(negedge clk);
    checkVal("on_again", status, S_ready);

    // Reset during CAPTURE drops the command
    sendCmd(OP_ADD, 1'b1, 8'h10, 8'h20);
    @(negedge clk);
    checkVal("capture_state", status, S_run);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(expQ.pop_front());
    shadowAcc = '0;
    checkVal("rst_mid_state", status, S_off);
    checkVal("rst_mid_valid", bus.rsp_valid, 0);
    checkVal("rst_mid_insel", inSel, SEL_RESET);
    checkVal("rst_mid_data", {bus.rsp_error, bus.rsp_data}, 0);
    sawValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sawValid = sawValid | bus.rsp_valid;
    end
    checkVal("no_rsp_after_rst", sawValid, 0);
    sendCmd(OP_ADD, 1'b0, 8'h00, 8'h02); collect(0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
